// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// No logic; purely declarations.
// No flow control.
package hazard_pkg;

  // Controller states: normal issue, post-branch squash, waiting on a cache miss
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 16;

  // Flush countdown width; holds FLUSH_CYCLES-2 for FLUSH_CYCLES up to 7
  localparam int FCNT_W = 3;

  // Register 0 is hard-wired and never carries a dependency
  localparam logic [DEF_REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_ctrl_unit_raw_match.sv
// Flags a read-after-write match between any valid ID source and one producer stage.
// Latency: purely combinational, zero cycles.
// No flow control; evaluated every cycle.
module raw_match
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = DEF_REG_AW
) (
  input  logic [NUM_SRC*REG_AW-1:0] src_id,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         dest,
  input  logic                      wb_en,
  output logic                      match
);

  // Any read operand that names the producer's (non-zero, written) destination
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_valid[k] && (src_id[k*REG_AW +: REG_AW] == dest)) match = 1'b1;
    end
    if (!wb_en || (dest == REG_AW'(REG_ZERO))) match = 1'b0;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: RAW stall, branch flush, cache-miss stall, perf counters.
// Latency: control outputs are combinational (zero cycles); state and counters registered.
// Cache miss dominates (global stall), then branch flush, then load-use/RAW freeze.
// Optional HAZARD_WATCHDOG_EN adds a sticky stall_timeout output.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = DEF_REG_AW,
  parameter int NUM_SRC      = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MAX_STALL    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fwd_en,
  input  logic [NUM_SRC*REG_AW-1:0] src_id,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         dest_exe,
  input  logic                      wb_en_exe,
  input  logic                      mem_r_en_exe,
  input  logic [REG_AW-1:0]         dest_mem,
  input  logic                      wb_en_mem,
  input  logic                      branch_taken,
  input  logic                      cache_ready,
  output logic                      freeze,
  output logic                      bubble,
  output logic                      flush,
  output logic                      stall_pipe,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
`ifdef HAZARD_WATCHDOG_EN
  ,
  output logic                      stall_timeout
`endif
);

  hz_state_t         state, state_nx;
  logic [FCNT_W-1:0] fcnt, fcnt_nx;
  logic              resume, resume_nx;
  logic              raw_exe, raw_mem, hazard, flushing;

  raw_match #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) u_raw_exe (
    .src_id    (src_id),
    .src_valid (src_valid),
    .dest      (dest_exe),
    .wb_en     (wb_en_exe),
    .match     (raw_exe)
  );

  raw_match #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) u_raw_mem (
    .src_id    (src_id),
    .src_valid (src_valid),
    .dest      (dest_mem),
    .wb_en     (wb_en_mem),
    .match     (raw_mem)
  );

  // With forwarding only a load in EXE cannot be bypassed in time
  assign hazard = fwd_en ? (raw_exe & mem_r_en_exe) : (raw_exe | raw_mem);

  // A flush interrupted by a miss picks up where it left off once the cache is ready
  assign flushing = (state == FLUSH) || ((state == MEM_WAIT) && resume);

  // State, flush countdown and resume marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      fcnt   <= '0;
      resume <= 1'b0;
    end else begin
      state  <= state_nx;
      fcnt   <= fcnt_nx;
      resume <= resume_nx;
    end
  end

  // Next state and zero-latency control outputs, priority miss > flush > hazard
  always_comb begin
    state_nx   = state;
    fcnt_nx    = fcnt;
    resume_nx  = resume;
    freeze     = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    stall_pipe = 1'b0;
    if (!cache_ready) begin
      stall_pipe = 1'b1;
      state_nx   = MEM_WAIT;
      // Remember on entry whether a flush was in progress; hold it while waiting
      if (state != MEM_WAIT) resume_nx = (state == FLUSH);
    end else if (flushing) begin
      flush     = 1'b1;
      resume_nx = 1'b0;
      if (fcnt == '0) begin
        state_nx = RUN;
      end else begin
        state_nx = FLUSH;
        fcnt_nx  = fcnt - FCNT_W'(1);
      end
    end else begin
      state_nx  = RUN;
      resume_nx = 1'b0;
      if (branch_taken) begin
        flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nx = FLUSH;
          fcnt_nx  = FCNT_W'(FLUSH_CYCLES - 2);
        end
      end else if (hazard) begin
        freeze = 1'b1;
        bubble = 1'b1;
      end
    end
    // Outputs stay quiet for as long as reset is held
    if (!rst_n) begin
      freeze     = 1'b0;
      bubble     = 1'b0;
      flush      = 1'b0;
      stall_pipe = 1'b0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze || stall_pipe) && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

`ifdef HAZARD_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_STALL + 2);
  logic [WD_W-1:0] wcnt;

  // Counts consecutive miss cycles (entry cycle counts as 1); flags once MAX_STALL is exceeded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt          <= '0;
      stall_timeout <= 1'b0;
    end else if (!cache_ready) begin
      if (state != MEM_WAIT) begin
        wcnt <= WD_W'(1);
      end else begin
        if (wcnt != {WD_W{1'b1}}) wcnt <= wcnt + WD_W'(1);
        if (wcnt >= WD_W'(MAX_STALL)) stall_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;
  localparam int REG_AW       = 5;
  localparam int NUM_SRC      = 2;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 5;
  localparam int MAX_STALL    = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      fwd_en;
  logic [NUM_SRC*REG_AW-1:0] src_id;
  logic [NUM_SRC-1:0]        src_valid;
  logic [REG_AW-1:0]         dest_exe, dest_mem;
  logic                      wb_en_exe, mem_r_en_exe, wb_en_mem;
  logic                      branch_taken, cache_ready;
  logic                      freeze, bubble, flush, stall_pipe;
  logic [CNT_W-1:0]          stall_cnt, flush_cnt;
`ifdef HAZARD_WATCHDOG_EN
  logic                      stall_timeout;
`endif

  hazard_ctrl_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .src_id(src_id), .src_valid(src_valid),
    .dest_exe(dest_exe), .wb_en_exe(wb_en_exe), .mem_r_en_exe(mem_r_en_exe),
    .dest_mem(dest_mem), .wb_en_mem(wb_en_mem), .branch_taken(branch_taken),
    .cache_ready(cache_ready), .freeze(freeze), .bubble(bubble), .flush(flush),
    .stall_pipe(stall_pipe), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`ifdef HAZARD_WATCHDOG_EN
    , .stall_timeout(stall_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: cycles of flush still owed, counters, consecutive-miss count
  int         m_rem, m_scnt, m_fcnt, m_wd;
  bit         m_to;
  logic [3:0] m_out;  // {freeze, bubble, flush, stall_pipe}
  wire  [3:0] dut_out = {freeze, bubble, flush, stall_pipe};

  function automatic bit raw(input logic [REG_AW-1:0] d, input logic we);
    bit r = 0;
    for (int k = 0; k < NUM_SRC; k++)
      if (src_valid[k] && we && d != 0 && src_id[k*REG_AW +: REG_AW] == d) r = 1;
    return r;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_scnt = 0; m_fcnt = 0; m_wd = 0; m_to = 0;
  endtask

  task automatic model_eval();
    bit hz;
    hz = fwd_en ? (raw(dest_exe, wb_en_exe) && mem_r_en_exe)
                : (raw(dest_exe, wb_en_exe) || raw(dest_mem, wb_en_mem));
    m_out = 4'b0000;
    if (rst_n !== 1'b1)                m_out = 4'b0000;
    else if (!cache_ready)             m_out = 4'b0001;
    else if (m_rem > 0 || branch_taken) m_out = 4'b0010;
    else if (hz)                       m_out = 4'b1100;
  endtask

  task automatic model_commit();
    if (rst_n !== 1'b1) begin model_reset(); return; end
    if (cache_ready) begin
      if (m_rem > 0) m_rem--;
      else if (branch_taken) m_rem = FLUSH_CYCLES - 1;
      m_wd = 0;
    end else begin
      m_wd++;
      if (m_wd > MAX_STALL) m_to = 1;
    end
    if ((m_out[3] || m_out[0]) && m_scnt < CNT_MAX) m_scnt++;
    if (m_out[1] && m_fcnt < CNT_MAX) m_fcnt++;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    model_eval();
    model_commit();
    #1;
  endtask

  task automatic drive(input logic fe, input logic [REG_AW-1:0] s1, input logic [REG_AW-1:0] s0,
                       input logic [1:0] sv, input logic [REG_AW-1:0] de, input logic we_e,
                       input logic ld, input logic [REG_AW-1:0] dm, input logic we_m,
                       input logic br, input logic cr);
    fwd_en = fe; src_id = {s1, s0}; src_valid = sv; dest_exe = de; wb_en_exe = we_e;
    mem_r_en_exe = ld; dest_mem = dm; wb_en_mem = we_m; branch_taken = br; cache_ready = cr;
  endtask

  task automatic idle();
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    // Inputs that would otherwise stall and hazard
    drive(1, 0, 5, 2'b01, 5, 1, 1, 0, 0, 1, 0);
    #2;
    n_run++;
    if (dut_out !== 4'b0000 || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs=%b cnt=%0d/%0d required 0000 0/0", dut_out, stall_cnt, flush_cnt);
    end
    tick();
    do_reset();
  endtask

  task automatic test_load_use();
    logic [3:0] exp [3];
    exp[0] = 4'b1100; exp[1] = 4'b0000; exp[2] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1, 0, 5, 2'b01, 5, 1, 1, 0, 0, 0, 1);   // load in EXE feeds src0
        1: drive(1, 0, 5, 2'b01, 5, 1, 0, 0, 0, 0, 1);   // ALU op: forwarded
        default: drive(1, 7, 0, 2'b10, 0, 0, 0, 7, 1, 0, 1); // MEM producer: forwarded
      endcase
      #2;
      n_run++;
      if (dut_out !== exp[i]) begin
        n_fail++;
        $display("FAIL load_use step%0d: outputs=%b required %b", i, dut_out, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_no_fwd();
    logic [3:0] exp [5];
    exp[0] = 4'b1100; exp[1] = 4'b0000; exp[2] = 4'b0000; exp[3] = 4'b1100; exp[4] = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(0, 7, 0, 2'b10, 3, 1, 0, 7, 1, 0, 1);   // src1 vs MEM dest
        1: drive(0, 7, 0, 2'b00, 3, 1, 0, 7, 1, 0, 1);   // operand not read
        2: drive(0, 0, 0, 2'b11, 0, 1, 0, 0, 1, 0, 1);   // register 0
        3: drive(0, 0, 9, 2'b01, 9, 1, 0, 0, 0, 0, 1);   // EXE ALU producer
        default: drive(0, 0, 9, 2'b01, 9, 0, 0, 9, 0, 0, 1); // no write-back
      endcase
      #2;
      n_run++;
      if (dut_out !== exp[i]) begin
        n_fail++;
        $display("FAIL no_fwd step%0d: outputs=%b required %b", i, dut_out, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [4:0] br_seq  = 5'b00101;  // second branch lands inside the flush window
    logic [4:0] hz_seq  = 5'b00010;
    logic [4:0] exp_fl  = 5'b00111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 5, {1'b0, hz_seq[i]}, 5, 1, 1, 0, 0, br_seq[i], 1);
      #2;
      n_run++;
      if (dut_out !== {2'b00, exp_fl[i], 1'b0}) begin
        n_fail++;
        $display("FAIL flush cyc%0d: outputs=%b required %b", i, dut_out, {2'b00, exp_fl[i], 1'b0});
      end
      tick();
    end
    n_run++;
    if (flush_cnt !== 5'd3) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d required 3", flush_cnt);
    end
  endtask

  task automatic test_cache_stall();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 11) drive(1, 0, 5, 2'b01, 5, 1, 1, 0, 0, 0, (i >= 10));
      else        idle();
      #2;
      n_run++;
      if (dut_out !== (i < 10 ? 4'b0001 : (i == 10 ? 4'b1100 : 4'b0000))) begin
        n_fail++;
        $display("FAIL cache_stall cyc%0d: outputs=%b", i, dut_out);
      end
      tick();
    end
    n_run++;
    if (stall_cnt !== 5'd11) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d required 11", stall_cnt);
    end
  endtask

  task automatic test_flush_miss();
    logic [6:0] cr_seq = 7'b1110001;
    logic [6:0] exp_fl = 7'b0110001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, (i == 0), cr_seq[i]);
      #2;
      n_run++;
      if (dut_out !== {2'b00, exp_fl[i], ~cr_seq[i]}) begin
        n_fail++;
        $display("FAIL flush_miss cyc%0d: outputs=%b required %b", i, dut_out, {2'b00, exp_fl[i], ~cr_seq[i]});
      end
      tick();
    end
    n_run++;
    if (flush_cnt !== 5'd3 || stall_cnt !== 5'd3) begin
      n_fail++;
      $display("FAIL flush_miss_cnt: flush=%0d stall=%0d required 3/3", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 5, 2'b01, 5, 1, 1, 0, 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_run++;
    if (dut_out !== 4'b0000 || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: outputs=%b cnt=%0d/%0d required 0000 0/0", dut_out, stall_cnt, flush_cnt);
    end
    tick();
    rst_n = 1'b1;
    idle();
    #2;
    n_run++;
    if (dut_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_release: outputs=%b required 0000", dut_out);
    end
    tick();
  endtask

`ifdef HAZARD_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, (i >= 5));
      tick();
      #1;
      n_run++;
      if (stall_timeout !== (i >= 4)) begin
        n_fail++;
        $display("FAIL watchdog cyc%0d: stall_timeout=%b required %b", i, stall_timeout, (i >= 4));
      end
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_run++;
    if (stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_reset: stall_timeout=%b required 0", stall_timeout);
    end
    tick();
    rst_n = 1'b1;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0));
      #2;
      model_eval();
      n_run++;
      if (dut_out !== m_out) begin
        n_fail++;
        $display("FAIL random_out cyc%0d: outputs=%b required %b", i, dut_out, m_out);
      end
      n_run++;
      if (stall_cnt !== CNT_W'(m_scnt) || flush_cnt !== CNT_W'(m_fcnt)) begin
        n_fail++;
        $display("FAIL random_cnt cyc%0d: stall=%0d flush=%0d required %0d %0d",
                 i, stall_cnt, flush_cnt, m_scnt, m_fcnt);
      end
`ifdef HAZARD_WATCHDOG_EN
      n_run++;
      if (stall_timeout !== m_to) begin
        n_fail++;
        $display("FAIL random_timeout cyc%0d: stall_timeout=%b required %b", i, stall_timeout, m_to);
      end
`endif
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_fwd();
    test_flush();
    test_cache_stall();
    test_flush_miss();
    test_reset_mid();
`ifdef HAZARD_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
